seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for NUM_DIGITS common-anode/cathode 7-segment digits sharing one segment bus. It latches a packed hex value through a load strobe into a staging register. The value is moved to the displayed (shadow) register only at a frame boundary, so the display never tears. The block scans digits with a programmable dwell and an anti-ghosting blank window, and decodes each nibble on-chip. It sits between the game/score logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < SCAN_DIV)
SEG_ACTIVE_LOW, 1, 1 = segment/dp lit when 0
AN_ACTIVE_LOW, 1, 1 = digit enable asserted when 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  single-cycle strobe: capture value/blank_mask/dp_mask into staging
value  in  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
blank_mask  in  NUM_DIGITS  1 = force digit dark
dp_mask  in  NUM_DIGITS  1 = decimal point lit on that digit
seg  out  7  segment bus {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, same polarity as seg
an  out  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse after the last digit slot of each frame
pending  out  1  staged data not yet displayed

Behaviour:
- Reset (sync, high): div_cnt=0, digit_idx=0. Staging, shadow and pending cleared. seg/dp all unlit, an all inactive, frame_done=0.
- div_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, digit_idx increments and goes NUM_DIGITS-1 -> 0.
- Frame boundary: the cycle with div_cnt==SCAN_DIV-1 and digit_idx==NUM_DIGITS-1.
  - frame_done is high in the following cycle.
  - If pending=1, shadow<=staging and pending clears.
- load=1: staging<=inputs and pending<=1 in the next cycle. Back-to-back loads overwrite staging; the last one wins.
- load coincident with a frame boundary: shadow takes the old staging contents. The new data enters staging, pending stays 1, and the new data is displayed at the next boundary.
- Outputs are registered with one-cycle latency. They are a function of the previous cycle's digit_idx, div_cnt and shadow.
- Blank window: when div_cnt < BLANK_CYCLES, an is all inactive and seg/dp are unlit.
- Otherwise, an asserts bit digit_idx only. seg = decode(shadow nibble[digit_idx]) and dp = dp_mask[digit_idx].
- Digit dark (blank_mask=1, or suppressed): seg and dp are unlit, but an stays asserted for uniform duty.
- Decode table (active-low form, inverted when SEG_ACTIVE_LOW=0):
  0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0011000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
- Reset mid-frame: immediate return to reset state next cycle; staged data is lost.

Optional Feature:
- SEG7_LEAD_ZERO_SUPPRESS_EN defined:
  - A digit i>0 is dark when its shadow nibble and all higher nibbles are 0.
  - Digit 0 is never suppressed.
  - dp_mask still lights dp on a suppressed digit.
- Undefined: all digits are decoded literally, so zeros show as "0".

Decomposition:
- Package seg7_pkg:
  - SEG7_HEX_LUT (16 x 7-bit, active-low form)
  - SEG7_BLANK constant (7'b1111111)
  - function seg7_apply_pol(pattern, active_low)
- Sub-module seg7_hex_decode: combinational nibble -> 7-bit pattern via the LUT. Instanced once on the muxed nibble.
- Counters, staging/shadow, pending logic and output registers live in the top module.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low polarity.
1. Reset held 3 cycles, then released -> during reset seg=7'h7F, an=4'hF, frame_done=0. First an=4'b1110 appears at post-release cycle 3; frame_done first pulses 32 cycles after release.
2. load with value=16'h12AF, masks 0, mid-frame -> pending=1 until the boundary. Next frame shows an=1110 seg=0001110, an=1101 seg=0001000, an=1011 seg=0100100, an=0111 seg=1111001.
3. load asserted exactly on a boundary cycle with value=16'h3333, after a prior pending load of 16'h1111 -> 1111 is displayed this frame and 3333 the next; pending is high throughout.
4. blank_mask=4'b0100, dp_mask=4'b0001 -> digit 2 has seg=7'h7F with an still asserted; digit 0 has dp=0. In every slot an=4'hF for the first 2 cycles.
5. value=16'h0007 -> with macro: digits 3..1 have seg=7'h7F and digit 0 has seg=1111000. Without macro: digits 3..1 have seg=1000000.
6. reset pulsed mid-slot on digit 2 with pending=1 -> next cycle all outputs are at reset values, pending=0, and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
//   SEG7_HEX_LUT   : hex digit -> segment pattern {g,f,e,d,c,b,a}, active-low form (0 = lit)
//   SEG7_BLANK     : all segments off, active-low form
//   seg7_apply_pol : converts an active-low pattern to the pin polarity in use
package seg7_pkg;

   localparam logic [6:0] SEG7_HEX_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,  // 8 9 A b
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
   };

   localparam logic [6:0] SEG7_BLANK = 7'b1111111;

   function automatic logic [6:0] seg7_apply_pol(input logic [6:0] pattern,
                                                 input bit         active_low);
      return active_low ? pattern : ~pattern;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-nibble to 7-segment decoder.
//   nibble_i  : 4-bit hex digit
//   pattern_o : segment pattern {g,f,e,d,c,b,a}, active-low form
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] pattern_o
);

   assign pattern_o = SEG7_HEX_LUT[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS 7-segment digits on a shared segment bus.
// A load strobe captures value/masks into a staging register; staged data moves to the
// displayed (shadow) register only at a frame boundary so a frame never mixes two values.
// Each digit slot lasts SCAN_DIV cycles, the first BLANK_CYCLES with every anode off.
//
// Ports:
//   clk_i        : system clock
//   reset_i      : synchronous, active-high reset
//   load_i       : one-cycle strobe, captures value_i/blank_mask_i/dp_mask_i into staging
//   value_i      : packed nibbles, digit 0 in bits [3:0] (rightmost)
//   blank_mask_i : 1 = digit forced dark
//   dp_mask_i    : 1 = decimal point lit on that digit
//   seg_o        : segment bus {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   dp_o         : decimal point, same polarity as seg_o
//   an_o         : one-hot digit enable, polarity set by AN_ACTIVE_LOW
//   frame_done_o : one-cycle pulse after the last slot of each frame
//   pending_o    : staged data not yet displayed
//
// Build option: define SEG7_LEAD_ZERO_SUPPRESS_EN to darken leading zero digits (digit 0
// always shown; dp_mask still lights dp on a suppressed digit).
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   blank_mask_i,
   input  logic [NUM_DIGITS-1:0]   dp_mask_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_done_o,
   output logic                    pending_o
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CntW-1:0]       CntLast  = CntW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0]       BlankEnd = CntW'(BLANK_CYCLES);
   localparam logic [IdxW-1:0]       IdxLast  = IdxW'(NUM_DIGITS - 1);
   localparam logic [6:0]            SegOff   = seg7_apply_pol(SEG7_BLANK, SEG_ACTIVE_LOW);
   localparam logic                  DpOff    = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AnOff    = {NUM_DIGITS{AN_ACTIVE_LOW}};

   logic [CntW-1:0]         div_cnt_q, div_cnt_d;
   logic [IdxW-1:0]         digit_idx_q, digit_idx_d;
   logic [4*NUM_DIGITS-1:0] stage_val_q, stage_val_d, shadow_val_q, shadow_val_d;
   logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d, shadow_blank_q, shadow_blank_d;
   logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
   logic                    pending_q, pending_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    frame_done_q, frame_done_d;

   logic       slot_end, frame_end;
   logic [3:0] nibble;
   logic [6:0] pattern;
   logic       seg_dark, dp_lit;
`ifdef SEG7_LEAD_ZERO_SUPPRESS_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  above_zero;
`endif

   seg7_hex_decode u_decode (
      .nibble_i  (nibble),
      .pattern_o (pattern)
   );

   assign slot_end  = (div_cnt_q == CntLast);
   assign frame_end = slot_end && (digit_idx_q == IdxLast);

   // Counters, staging/shadow and pending.
   always_comb begin
      div_cnt_d      = slot_end ? '0 : div_cnt_q + 1'b1;
      digit_idx_d    = digit_idx_q;
      stage_val_d    = stage_val_q;
      stage_blank_d  = stage_blank_q;
      stage_dp_d     = stage_dp_q;
      shadow_val_d   = shadow_val_q;
      shadow_blank_d = shadow_blank_q;
      shadow_dp_d    = shadow_dp_q;
      pending_d      = pending_q;
      if (slot_end) begin
         digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
      end
      // Shadow takes the staging contents as they stand before any coincident load.
      if (frame_end && pending_q) begin
         shadow_val_d   = stage_val_q;
         shadow_blank_d = stage_blank_q;
         shadow_dp_d    = stage_dp_q;
         pending_d      = 1'b0;
      end
      if (load_i) begin
         stage_val_d   = value_i;
         stage_blank_d = blank_mask_i;
         stage_dp_d    = dp_mask_i;
         pending_d     = 1'b1;
      end
   end

   // Select the current digit and decide whether it is dark.
   always_comb begin
      nibble   = 4'h0;
      seg_dark = 1'b0;
      dp_lit   = 1'b0;
`ifdef SEG7_LEAD_ZERO_SUPPRESS_EN
      above_zero = 1'b1;
      lead_zero  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         above_zero   = above_zero && (shadow_val_q[4*i +: 4] == 4'h0);
         lead_zero[i] = above_zero;
      end
`endif
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx_q == IdxW'(i)) begin
            nibble   = shadow_val_q[4*i +: 4];
            seg_dark = shadow_blank_q[i];
            dp_lit   = shadow_dp_q[i] && !shadow_blank_q[i];
`ifdef SEG7_LEAD_ZERO_SUPPRESS_EN
            if (i != 0 && lead_zero[i]) begin
               seg_dark = 1'b1;
            end
`endif
         end
      end
   end

   // Registered outputs; a dark digit keeps its anode on so every digit has equal duty.
   always_comb begin
      an_d         = AnOff;
      seg_d        = SegOff;
      dp_d         = DpOff;
      frame_done_d = frame_end;
      if (div_cnt_q >= BlankEnd) begin
         an_d  = (NUM_DIGITS'(1) << digit_idx_q) ^ AnOff;
         seg_d = seg_dark ? SegOff : seg7_apply_pol(pattern, SEG_ACTIVE_LOW);
         dp_d  = dp_lit ? ~DpOff : DpOff;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_cnt_q      <= '0;
         digit_idx_q    <= '0;
         stage_val_q    <= '0;
         stage_blank_q  <= '0;
         stage_dp_q     <= '0;
         shadow_val_q   <= '0;
         shadow_blank_q <= '0;
         shadow_dp_q    <= '0;
         pending_q      <= 1'b0;
         seg_q          <= SegOff;
         dp_q           <= DpOff;
         an_q           <= AnOff;
         frame_done_q   <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         digit_idx_q    <= digit_idx_d;
         stage_val_q    <= stage_val_d;
         stage_blank_q  <= stage_blank_d;
         stage_dp_q     <= stage_dp_d;
         shadow_val_q   <= shadow_val_d;
         shadow_blank_q <= shadow_blank_d;
         shadow_dp_q    <= shadow_dp_d;
         pending_q      <= pending_d;
         seg_q          <= seg_d;
         dp_q           <= dp_d;
         an_q           <= an_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign an_o         = an_q;
   assign frame_done_o = frame_done_q;
   assign pending_o    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low.
// cyc counts clock edges since the last reset cycle; outputs seen in cycle k reflect the
// counters of cycle k-1 (digit = ((k-1)/8)%4, slot position = (k-1)%8).
module tb_seg7_scan_driver;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        load_i = 1'b0;
   logic [15:0] value_i = '0;
   logic [3:0]  blank_mask_i = '0;
   logic [3:0]  dp_mask_i = '0;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic [3:0]  an_o;
   logic        frame_done_o;
   logic        pending_o;

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

`ifdef SEG7_LEAD_ZERO_SUPPRESS_EN
   localparam logic [6:0] ZS = 7'h7F;
`else
   localparam logic [6:0] ZS = 7'h40;
`endif

   seg7_scan_driver #(
      .NUM_DIGITS     (4),
      .SCAN_DIV       (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .load_i       (load_i),
      .value_i      (value_i),
      .blank_mask_i (blank_mask_i),
      .dp_mask_i    (dp_mask_i),
      .seg_o        (seg_o),
      .dp_o         (dp_o),
      .an_o         (an_o),
      .frame_done_o (frame_done_o),
      .pending_o    (pending_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int unsigned cyc;
      logic        rst;
      logic        load;
      logic [15:0] val;
      logic [3:0]  bm;
      logic [3:0]  dm;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        pend;
      logic        fd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(int unsigned c, logic r, logic l, logic [15:0] val,
                              logic [3:0] bm, logic [3:0] dm, logic [3:0] an,
                              logic [6:0] seg, logic dp, logic pend, logic fd);
      vec_t x;
      x.cyc = c; x.rst = r; x.load = l; x.val = val; x.bm = bm; x.dm = dm;
      x.an = an; x.seg = seg; x.dp = dp; x.pend = pend; x.fd = fd;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic check_all(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                            input logic pend, input logic fd);
      check("an", 32'(an_o), 32'(an));
      check("seg", 32'(seg_o), 32'(seg));
      check("dp", 32'(dp_o), 32'(dp));
      check("pending", 32'(pending_o), 32'(pend));
      check("frame_done", 32'(frame_done_o), 32'(fd));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
      load_i = 1'b0;
   endtask

   initial begin
      bit seen;

      // Reset held 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all(4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
      end
      reset_i = 1'b0;
      cyc = 0;

      //             cyc  rst ld  value     bm    dm    an    seg    dp  pnd fd
      vecs.push_back(v(1,   0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(2,   0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(3,   0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h40, 1, 0, 0));
      vecs.push_back(v(31,  0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 0, 0));
      vecs.push_back(v(32,  0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 0, 1));
      vecs.push_back(v(33,  0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      // mid-frame load of 12AF
      vecs.push_back(v(40,  0, 1, 16'h12AF, 4'h0, 4'h0, 4'hE, 7'h40, 1, 0, 0));
      vecs.push_back(v(41,  0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 1, 0));
      vecs.push_back(v(63,  0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 1, 0));
      vecs.push_back(v(64,  0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 0, 1));
      vecs.push_back(v(68,  0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h0E, 1, 0, 0));
      vecs.push_back(v(76,  0, 0, 16'h0,    4'h0, 4'h0, 4'hD, 7'h08, 1, 0, 0));
      vecs.push_back(v(84,  0, 0, 16'h0,    4'h0, 4'h0, 4'hB, 7'h24, 1, 0, 0));
      vecs.push_back(v(92,  0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h79, 1, 0, 0));
      // 1111 pending, then 3333 loaded on the boundary cycle 127
      vecs.push_back(v(100, 0, 1, 16'h1111, 4'h0, 4'h0, 4'hE, 7'h0E, 1, 0, 0));
      vecs.push_back(v(101, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h0E, 1, 1, 0));
      vecs.push_back(v(127, 0, 1, 16'h3333, 4'h0, 4'h0, 4'h7, 7'h79, 1, 1, 0));
      vecs.push_back(v(128, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h79, 1, 1, 1));
      vecs.push_back(v(132, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h79, 1, 1, 0));
      vecs.push_back(v(156, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h79, 1, 1, 0));
      vecs.push_back(v(160, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h79, 1, 0, 1));
      vecs.push_back(v(164, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h30, 1, 0, 0));
      vecs.push_back(v(188, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h30, 1, 0, 0));
      // 5678 with digit 2 blanked and dp on digit 0
      vecs.push_back(v(190, 0, 1, 16'h5678, 4'h4, 4'h1, 4'h7, 7'h30, 1, 0, 0));
      vecs.push_back(v(191, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h30, 1, 1, 0));
      vecs.push_back(v(192, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h30, 1, 0, 1));
      vecs.push_back(v(193, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(194, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(195, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h00, 0, 0, 0));
      vecs.push_back(v(200, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h00, 0, 0, 0));
      vecs.push_back(v(201, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(202, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(203, 0, 0, 16'h0,    4'h0, 4'h0, 4'hD, 7'h78, 1, 0, 0));
      vecs.push_back(v(211, 0, 0, 16'h0,    4'h0, 4'h0, 4'hB, 7'h7F, 1, 0, 0));
      vecs.push_back(v(216, 0, 0, 16'h0,    4'h0, 4'h0, 4'hB, 7'h7F, 1, 0, 0));
      vecs.push_back(v(217, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(219, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h12, 1, 0, 0));
      // 0007: leading zeros
      vecs.push_back(v(222, 0, 1, 16'h0007, 4'h0, 4'h0, 4'h7, 7'h12, 1, 0, 0));
      vecs.push_back(v(228, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h78, 1, 0, 0));
      vecs.push_back(v(236, 0, 0, 16'h0,    4'h0, 4'h0, 4'hD, ZS,    1, 0, 0));
      vecs.push_back(v(244, 0, 0, 16'h0,    4'h0, 4'h0, 4'hB, ZS,    1, 0, 0));
      vecs.push_back(v(252, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, ZS,    1, 0, 0));
      // reset mid-slot on digit 2 with 8888 pending
      vecs.push_back(v(260, 0, 1, 16'h8888, 4'h0, 4'h0, 4'hE, 7'h78, 1, 0, 0));
      vecs.push_back(v(268, 0, 0, 16'h0,    4'h0, 4'h0, 4'hD, ZS,    1, 1, 0));
      vecs.push_back(v(274, 1, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 1, 0));
      vecs.push_back(v(275, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(277, 0, 0, 16'h0,    4'h0, 4'h0, 4'hF, 7'h7F, 1, 0, 0));
      vecs.push_back(v(278, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h40, 1, 0, 0));
      vecs.push_back(v(306, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 0, 0));
      vecs.push_back(v(307, 0, 0, 16'h0,    4'h0, 4'h0, 4'h7, 7'h40, 1, 0, 1));
      vecs.push_back(v(311, 0, 0, 16'h0,    4'h0, 4'h0, 4'hE, 7'h40, 1, 0, 0));

      foreach (vecs[j]) begin
         while (cyc < vecs[j].cyc) tick();
         check_all(vecs[j].an, vecs[j].seg, vecs[j].dp, vecs[j].pend, vecs[j].fd);
         reset_i      = vecs[j].rst;
         load_i       = vecs[j].load;
         value_i      = vecs[j].val;
         blank_mask_i = vecs[j].bm;
         dp_mask_i    = vecs[j].dm;
      end

      // Back-to-back loads: the second one must be what gets displayed.
      tick();
      load_i = 1'b1; value_i = 16'hAAAA; blank_mask_i = 4'h0; dp_mask_i = 4'h0;
      tick();
      load_i = 1'b1; value_i = 16'hBCDE;
      tick();
      check("pending_b2b", 32'(pending_o), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         tick();
         seen = frame_done_o;
      end
      check("frame_done_seen", 32'(seen), 32'd1);
      check("frame_done_cyc", cyc, 32'd339);
      check("pending_cleared", 32'(pending_o), 32'd0);
      repeat (4) tick();
      check("b2b_an0", 32'(an_o), 32'hE);
      check("b2b_seg0", 32'(seg_o), 32'h06);
      repeat (24) tick();
      check("b2b_an3", 32'(an_o), 32'h7);
      check("b2b_seg3", 32'(seg_o), 32'h03);
      check("b2b_dp3", 32'(dp_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
